// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters. Operands are latched and
// the ALU is driven for one cycle, then the registered result is handed back.
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic [DATA_W-1:0] alu_input1,
  output logic [DATA_W-1:0] alu_input2,
  output logic [OP_W-1:0]   alu_operation,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   rsp_hs;
  logic   can_accept;
  logic   grant0;
  logic   grant1;

  // Grant is combinational: a new op may be taken in IDLE or in the cycle the
  // pending response is consumed. On a tie the port not granted last wins.
  always_comb begin
    rsp_hs     = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);
    can_accept = !RESET && ((state == IDLE) || rsp_hs);
    grant0     = can_accept && req0_valid && (!req1_valid || last_grant);
    grant1     = can_accept && req1_valid && (!req0_valid || !last_grant);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      owner         <= 1'b0;
      last_grant    <= 1'b1;
      alu_input1    <= '0;
      alu_input2    <= '0;
      alu_operation <= '0;
      rsp_result    <= '0;
      rsp_zero      <= 1'b0;
      rsp0_valid    <= 1'b0;
      rsp1_valid    <= 1'b0;
      busy          <= 1'b0;
      op_count      <= '0;
    end else begin
      // Operand latches double as the ALU drive and hold across all states.
      if (grant0 || grant1) begin
        alu_input1    <= grant1 ? req1_a  : req0_a;
        alu_input2    <= grant1 ? req1_b  : req0_b;
        alu_operation <= grant1 ? req1_op : req0_op;
        owner         <= grant1;
        last_grant    <= grant1;
      end

      unique case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            state <= EXEC;
            busy  <= 1'b1;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp0_valid <= !owner;
          rsp1_valid <= owner;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            op_count   <= op_count + CNT_W'(1);
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (grant0 || grant1) begin
              state <= EXEC;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: transaction-level model with timestamps checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_alu_share_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned OW = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [OW-1:0] req0_op = '0, req1_op = '0;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [DW-1:0] rsp_result;
  logic          rsp_zero;
  logic [DW-1:0] alu_input1, alu_input2, alu_result;
  logic [OW-1:0] alu_operation;
  logic          alu_zero;
  logic          busy;
  logic [CW-1:0] op_count;

  int n_cmp = 0;
  int n_bad = 0;
  int grants[$];

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(DW), .OP_W(OW), .CNT_W(CW)) dut (
    .CLK(clk), .RESET(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .op_count(op_count)
  );

  // Stand-in ALU; the arbiter only transports whatever it produces.
  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [OW-1:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      4'd6:    return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
      4'd7:    return (a < b) ? DW'(1) : DW'(0);
      4'd8:    return a << b[4:0];
      4'd9:    return a >> b[4:0];
      4'd15:   return DW'($signed(a) >>> b[4:0]);
      default: return a + b;
    endcase
  endfunction

  assign alu_result = alu_f(alu_input1, alu_input2, alu_operation);
  assign alu_zero   = (alu_result == '0);

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: at most one transaction in flight, stamped with its accept cycle.
  int            cyc = 0;
  bit            m_init = 1'b0, m_has = 1'b0, m_own = 1'b0, m_last = 1'b1;
  logic [DW-1:0] m_a = '0, m_b = '0;
  logic [OW-1:0] m_op = '0;
  int            m_acc = 0;
  logic [CW-1:0] m_cnt = '0;

  function automatic void model_view(output bit ev0, output bit ev1, output bit g0,
                                     output bit g1, output bit hs);
    bit free;
    ev0  = m_has && !m_own && (cyc >= m_acc + 2);
    ev1  = m_has &&  m_own && (cyc >= m_acc + 2);
    hs   = (ev0 && rsp0_ready) || (ev1 && rsp1_ready);
    free = !rst && (!m_has || hs);
    g0   = free && req0_valid && (!req1_valid || m_last);
    g1   = free && req1_valid && (!req0_valid || !m_last);
  endfunction

  always @(negedge clk) begin
    bit ev0, ev1, g0, g1, hs;
    logic [DW-1:0] exp_r;
    if (m_init) begin
      model_view(ev0, ev1, g0, g1, hs);
      exp_r = alu_f(m_a, m_b, m_op);
      cmp("req0_ready", DW'(req0_ready), DW'(g0));
      cmp("req1_ready", DW'(req1_ready), DW'(g1));
      cmp("rsp0_valid", DW'(rsp0_valid), DW'(ev0));
      cmp("rsp1_valid", DW'(rsp1_valid), DW'(ev1));
      cmp("busy", DW'(busy), DW'(m_has));
      cmp("op_count", DW'(op_count), DW'(m_cnt));
      if (ev0 || ev1) begin
        cmp("rsp_result", rsp_result, exp_r);
        cmp("rsp_zero", DW'(rsp_zero), DW'(exp_r == '0));
      end
      if (m_has && cyc == m_acc + 1) begin
        cmp("alu_input1", alu_input1, m_a);
        cmp("alu_input2", alu_input2, m_b);
        cmp("alu_operation", DW'(alu_operation), DW'(m_op));
      end
    end
  end

  always @(posedge clk) begin
    bit ev0, ev1, g0, g1, hs;
    model_view(ev0, ev1, g0, g1, hs);
    if (rst) begin
      m_init = 1'b1;
      m_has  = 1'b0;
      m_last = 1'b1;
      m_cnt  = '0;
    end else if (m_init) begin
      if (hs) begin
        m_cnt = m_cnt + 1'b1;
        m_has = 1'b0;
      end
      if (g0 || g1) begin
        m_has  = 1'b1;
        m_own  = g1;
        m_last = g1;
        m_a    = g1 ? req1_a  : req0_a;
        m_b    = g1 ? req1_b  : req0_b;
        m_op   = g1 ? req1_op : req0_op;
        m_acc  = cyc;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_opnd();
    return ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
  endfunction

  task automatic single_op();
    req0_valid = 1'b1; req0_a = 5; req0_b = 3; req0_op = 4'd0;
    settle();
    cmp("s1_req0_ready", DW'(req0_ready), 1);
    cmp("s1_req1_ready", DW'(req1_ready), 0);
    step();
    req0_valid = 1'b0;
    settle();
    cmp("s1_busy_exec", DW'(busy), 1);
    cmp("s1_rsp0_valid_exec", DW'(rsp0_valid), 0);
    step();
    settle();
    cmp("s1_rsp0_valid", DW'(rsp0_valid), 1);
    cmp("s1_rsp_result", rsp_result, 8);
    cmp("s1_rsp_zero", DW'(rsp_zero), 0);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    settle();
    cmp("s1_op_count", DW'(op_count), 1);
    cmp("s1_busy_after", DW'(busy), 0);
    cmp("s1_rsp0_valid_after", DW'(rsp0_valid), 0);
  endtask

  // Keep enabled ports requesting with random operands until n grants are seen.
  task automatic run_ops(input bit en0, input bit en1, input int n);
    grants.delete();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int t = 0; t < 400 && grants.size() < n; t++) begin
      req0_valid = en0; req0_a = rand_opnd(); req0_b = rand_opnd(); req0_op = OW'($urandom_range(0, 15));
      req1_valid = en1; req1_a = rand_opnd(); req1_b = rand_opnd(); req1_op = OW'($urandom_range(0, 15));
      settle();
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (grants.size() < n) cmp("run_ops_timeout", DW'(grants.size()), DW'(n));
    repeat (4) step();
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    settle();
    cmp("rst_busy", DW'(busy), 0);
    cmp("rst_rsp0_valid", DW'(rsp0_valid), 0);
    cmp("rst_rsp1_valid", DW'(rsp1_valid), 0);
    cmp("rst_rsp_result", rsp_result, 0);
    cmp("rst_rsp_zero", DW'(rsp_zero), 0);
    cmp("rst_alu_input1", alu_input1, 0);
    cmp("rst_alu_input2", alu_input2, 0);
    cmp("rst_alu_operation", DW'(alu_operation), 0);
    cmp("rst_op_count", DW'(op_count), 0);

    single_op();

    // Simultaneous requests from reset: port 0 first, then port 1 back-to-back.
    do_reset();
    req0_valid = 1'b1; req0_a = 7;     req0_b = 7;     req0_op = 4'd1;
    req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 4'd3;
    settle();
    cmp("s2_req0_ready", DW'(req0_ready), 1);
    cmp("s2_req1_ready", DW'(req1_ready), 0);
    step();
    req0_valid = 1'b0;
    step();
    settle();
    cmp("s2_rsp0_valid", DW'(rsp0_valid), 1);
    cmp("s2_rsp1_valid", DW'(rsp1_valid), 0);
    cmp("s2_result0", rsp_result, 0);
    cmp("s2_zero0", DW'(rsp_zero), 1);
    cmp("s2_req1_ready_held", DW'(req1_ready), 0);
    rsp0_ready = 1'b1;
    settle();
    cmp("s2_req1_ready_b2b", DW'(req1_ready), 1);
    step();
    rsp0_ready = 1'b0;
    req1_valid = 1'b0;
    step();
    settle();
    cmp("s2_rsp1_valid", DW'(rsp1_valid), 1);
    cmp("s2_rsp0_valid_off", DW'(rsp0_valid), 0);
    cmp("s2_result1", rsp_result, 32'hFF);
    cmp("s2_zero1", DW'(rsp_zero), 0);
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;
    settle();
    cmp("s2_op_count", DW'(op_count), 2);

    // Fairness: both ports always requesting.
    do_reset();
    run_ops(1'b1, 1'b1, 8);
    for (int i = 0; i < 8 && i < grants.size(); i++)
      cmp($sformatf("fair_grant%0d", i), DW'(grants[i]), DW'(i % 2));
    cmp("fair_op_count", DW'(op_count), 8);
    cmp("fair_busy", DW'(busy), 0);

    // Backpressure on port 1, then back-to-back accept of port 0.
    do_reset();
    req1_valid = 1'b1; req1_a = 9; req1_b = 4; req1_op = 4'd0;
    settle();
    cmp("bp_req1_ready", DW'(req1_ready), 1);
    step();
    req1_valid = 1'b0;
    step();
    req0_valid = 1'b1; req0_a = 2; req0_b = 2; req0_op = 4'd1;
    for (int i = 0; i < 5; i++) begin
      settle();
      cmp("bp_rsp1_valid", DW'(rsp1_valid), 1);
      cmp("bp_result", rsp_result, 13);
      cmp("bp_req0_ready", DW'(req0_ready), 0);
      step();
    end
    rsp1_ready = 1'b1;
    settle();
    cmp("bp_req0_ready_b2b", DW'(req0_ready), 1);
    step();
    rsp1_ready = 1'b0;
    req0_valid = 1'b0;
    settle();
    cmp("bp_busy_exec", DW'(busy), 1);
    cmp("bp_rsp0_valid_exec", DW'(rsp0_valid), 0);
    cmp("bp_op_count1", DW'(op_count), 1);
    step();
    settle();
    cmp("bp_rsp0_valid", DW'(rsp0_valid), 1);
    cmp("bp_result0", rsp_result, 0);
    cmp("bp_zero0", DW'(rsp_zero), 1);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    settle();
    cmp("bp_op_count2", DW'(op_count), 2);

    // Reset while the op is in EXEC discards it.
    req0_valid = 1'b1; req0_a = 1; req0_b = 1; req0_op = 4'd0;
    step();
    req0_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    cmp("mid_busy", DW'(busy), 0);
    cmp("mid_rsp0_valid", DW'(rsp0_valid), 0);
    cmp("mid_rsp1_valid", DW'(rsp1_valid), 0);
    cmp("mid_op_count", DW'(op_count), 0);
    step();
    single_op();

    // 4-bit counter wraps after 16.
    do_reset();
    run_ops(1'b1, 1'b0, 17);
    cmp("wrap_op_count", DW'(op_count), 1);

    // Random traffic, occasional resets.
    for (int t = 0; t < 1500; t++) begin
      rst        = ($urandom_range(0, 199) == 0);
      req0_valid = ($urandom_range(0, 9) < 6);
      req0_a = rand_opnd(); req0_b = rand_opnd(); req0_op = OW'($urandom_range(0, 15));
      req1_valid = ($urandom_range(0, 9) < 6);
      req1_a = rand_opnd(); req1_b = rand_opnd(); req1_op = OW'($urandom_range(0, 15));
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the core's single 32-bit ALU between two requesters: port 0 (execute stage) and port 1 (auxiliary unit, e.g. branch-target/compare helper).
- Arbitrates round-robin, latches operands, drives the ALU for one cycle, and registers the result and Zero flag.
- Returns the result to the winning requester over a valid/ready handshake with backpressure.
- Sits between the requesters and the ALU instance in the core.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU width.
- OP_W, 4, operation code width; codes are passed to the ALU unchanged (0000 ADD … 1111 SRA).
- CNT_W, 32, width of the completed-operation counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready.
- req0_a, req0_b  in  DATA_W  operands from requester 0.
- req0_op  in  OP_W  operation from requester 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as port 0, for requester 1.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 consumes the result.
- rsp1_valid  out  1  result for requester 1 available.
- rsp1_ready  in  1  requester 1 consumes the result.
- rsp_result  out  DATA_W  registered ALU result; shared by both responses.
- rsp_zero  out  1  registered ALU Zero flag.
- alu_input1, alu_input2  out  DATA_W  operands driven to the ALU.
- alu_operation  out  OP_W  operation code driven to the ALU.
- alu_result  in  DATA_W  ALU result (combinational).
- alu_zero  in  1  ALU Zero flag.
- busy  out  1  high whenever the state is not IDLE.
- op_count  out  CNT_W  number of completed response handshakes.

Behaviour:
- Reset values:
  - State = IDLE; all ready and valid outputs 0.
  - rsp_result = 0, rsp_zero = 0, alu_* = 0, op_count = 0, busy = 0.
  - last_grant = 1, so port 0 wins the first tie.
- States: IDLE, EXEC, RESP.
- IDLE:
  - If either reqN_valid is high, grant one port. reqN_ready is high combinationally for the granted port only.
  - On grant, latch a/b/op and owner = N; go to EXEC.
- Arbitration:
  - If only one port is valid, it wins.
  - If both are valid, the port other than last_grant wins; last_grant updates on every grant.
  - The non-granted ready stays 0.
- EXEC (exactly one cycle):
  - alu_input1/alu_input2/alu_operation come from the latched registers. These registers hold their value in all states.
  - At the clock edge, capture alu_result into rsp_result and alu_zero into rsp_zero; go to RESP.
- RESP:
  - rsp<owner>_valid = 1; the other rspN_valid = 0.
  - rsp_result and rsp_zero are stable until the handshake.
  - On rsp<owner>_ready = 1: op_count increments; it wraps modulo 2^CNT_W with no saturation.
  - In that same handshake cycle, arbitration runs as in IDLE: reqN_ready may assert and a new op is accepted, giving next state EXEC (back-to-back).
  - Without a new request, the next state is IDLE.
  - Without the handshake, stay in RESP indefinitely. No request is accepted.
- Latency: accept at edge k → rsp valid from cycle k+2. Peak throughput is one op per 2 cycles.
- reqN_ready never depends on reqN_valid of the same port being sampled in a later cycle. A request dropped before its ready is not recorded.
- rspN_ready asserted while rspN_valid is 0 is ignored.
- Operand widths:
  - Pure pass-through; no sign handling in this block.
  - Shift amounts are passed unmasked; the ALU defines the semantics.
- RESET asserted in any state (including EXEC or RESP): return to reset values on the next edge. The pending result is discarded with no response, and op_count is cleared.
- busy = (state != IDLE).

Test Plan:
- Single op, port 0: req0 a=5, b=3, op=0000 at cycle 0 → req0_ready=1 cycle 0; rsp0_valid=1 cycle 2, rsp_result=8, rsp_zero=0; rsp0_ready=1 → op_count=1, busy=0 the following cycle.
- Simultaneous requests: port 0 SUB 7-7, port 1 OR 0xF0|0x0F, both valid and held → port 0 first (result 0, rsp_zero=1, rsp0_valid only), then port 1 (result 0xFF, rsp1_valid only); ready never high on both ports in one cycle.
- Fairness: both ports continuously valid for 8 grants → grants alternate 0,1,0,1,…; op_count=8.
- Backpressure plus back-to-back: rsp1_ready held 0 for 5 cycles → rsp1_valid and rsp_result stable and no req ready; then rsp1_ready=1 with req0 valid → same-cycle req0_ready=1, next state EXEC, rsp0_valid 2 cycles after that.
- Reset mid-op: assert RESET during EXEC → next cycle busy=0, all valids 0, op_count=0; the next request behaves as in the first scenario.
- Counter wrap (CNT_W=4): 17 completed ops → op_count=1.
